prbs_gen_param: RTL

PRBS_GEN_PARAM -- requirements
Module: prbs_gen_param

---
 rtl/prbs_gen_param.sv | 111 +++++++++++
 1 files changed

// File: rtl/prbs_gen_param.sv
// PRBS7/9/15/23/31 word generator: DATA_W LFSR steps per word, valid/ready output that holds on stall.
// Word load takes one cycle; seed_load inserts one idle cycle before the first word of the new sequence.
module prbs_gen_param #(
  parameter int unsigned DATA_W       = 32,
  parameter logic [30:0] SEED_DEFAULT = 31'd2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        mode,
  input  logic              seed_load,
  input  logic [30:0]       seed,
  input  logic              err_inject,
  input  logic              out_ready,
  output logic [DATA_W-1:0] prbs_out,
  output logic              valid_out,
  output logic              lockup,
  output logic [31:0]       word_count
);

  logic [30:0]       s;
  logic [30:0]       s_next;
  logic [30:0]       st;
  logic [30:0]       seed_masked;
  logic [2:0]        m;
  logic              err_pend;
  logic              fb;
  logic              load;
  logic              accept;
  logic [DATA_W-1:0] word_next;
  logic [4:0]        n_cur;
  logic [4:0]        k_cur;
  logic [30:0]       mask_cur;

  function automatic logic [4:0] tap_n(input logic [2:0] md);
    case (md)
      3'd0:    tap_n = 5'd7;
      3'd1:    tap_n = 5'd9;
      3'd2:    tap_n = 5'd15;
      3'd3:    tap_n = 5'd23;
      default: tap_n = 5'd31;
    endcase
  endfunction

  function automatic logic [4:0] tap_k(input logic [2:0] md);
    case (md)
      3'd0:    tap_k = 5'd6;
      3'd1:    tap_k = 5'd5;
      3'd2:    tap_k = 5'd14;
      3'd3:    tap_k = 5'd18;
      default: tap_k = 5'd28;
    endcase
  endfunction

  function automatic logic [30:0] len_mask(input logic [2:0] md);
    len_mask = 31'h7FFF_FFFF >> (5'd31 - tap_n(md));
  endfunction

  assign n_cur       = tap_n(m);
  assign k_cur       = tap_k(m);
  assign mask_cur    = len_mask(m);
  assign seed_masked = seed & len_mask(mode);

  assign load   = (!valid_out || out_ready) && !seed_load;
  assign accept = valid_out && out_ready && !seed_load;

  // Unrolled DATA_W steps; the first feedback bit lands in the MSB.
  always_comb begin
    st        = s;
    fb        = 1'b0;
    word_next = '0;
    for (int j = 0; j < DATA_W; j++) begin
      fb                    = st[n_cur - 5'd1] ^ st[k_cur - 5'd1];
      word_next[DATA_W-1-j] = fb;
      st                    = ((st << 1) | {30'd0, fb}) & mask_cur;
    end
    s_next = st;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s          <= SEED_DEFAULT;
      m          <= 3'd4;
      prbs_out   <= '0;
      valid_out  <= 1'b0;
      lockup     <= 1'b0;
      word_count <= '0;
      err_pend   <= 1'b0;
    end else begin
      lockup <= 1'b0;
      if (accept) begin
        word_count <= word_count + 32'd1;
      end
      if (seed_load) begin
        m         <= mode;
        // An all-zero state would never leave zero, so substitute 1.
        s         <= (seed_masked == '0) ? 31'd1 : seed_masked;
        lockup    <= (seed_masked == '0);
        valid_out <= 1'b0;
        err_pend  <= 1'b0;
      end else if (load) begin
        s         <= s_next;
        prbs_out  <= word_next ^ DATA_W'(err_pend | err_inject);
        valid_out <= 1'b1;
        err_pend  <= 1'b0;
      end else if (err_inject) begin
        err_pend <= 1'b1;
      end
    end
  end

endmodule
